alu_share_arbiter: RTL

- Arbitrates one shared combinational ALU between two requesters, e.g. the main datapath and a branch/compare unit.
- Each requester presents a 4-bit ALU control code and two operands over a valid/ready handshake.
- The block latches the winning request, drives the ALU for one cycle, registers the result and returns it over a response valid/ready handshake.
- Grant order is round-robin; codes outside the legal set are rejected with an error flag.

---
 rtl/alu_share_arbiter_if.sv | 37 +++
 rtl/alu_share_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// One requester's link to the shared-ALU arbiter. A request is a 4-bit ALU
// control code plus two operands. It is passed on a valid/ready handshake.
// The response carries the registered result, the zero flag and the error
// flag, and it uses its own valid/ready handshake.
//
// Signals:
//   valid, ready        request handshake (requester -> arbiter)
//   ctrl, src1, src2    ALU control code and operands
//   rsp_valid, rsp_ready response handshake (arbiter -> requester)
//   result, zero, err   registered ALU result, zero flag, illegal-code flag
//
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [3:0]        ctrl;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              err;

  modport master (
    output valid, ctrl, src1, src2, rsp_ready,
    input  ready, rsp_valid, result, zero, err
  );

  modport slave (
    input  valid, ctrl, src1, src2, rsp_ready,
    output ready, rsp_valid, result, zero, err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between two requesters. Grants are
// round-robin. A granted op is latched and drives the ALU for exactly one
// cycle (ISSUE). The ALU output is registered, and the response is held in
// RESP until the owner takes it. An illegal control code skips ISSUE and
// returns err=1 with a zero result.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   req0, req1           requester links (alu_share_arbiter_if.slave)
//   alu_ctrl_o/src1_o/src2_o  operation driven to the shared ALU
//   alu_result_i/zero_i  combinational ALU outputs
//   busy_o               high whenever the arbiter is not in IDLE
module alu_share_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_share_arbiter_if.slave  req0,
  alu_share_arbiter_if.slave  req1,
  output logic [3:0]          alu_ctrl_o,
  output logic [DATA_W-1:0]   alu_src1_o,
  output logic [DATA_W-1:0]   alu_src2_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                alu_zero_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CTRL_ADD = 4'b0010;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [3:0]        op_ctrl_q;
  logic [DATA_W-1:0] op_src1_q, op_src2_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, err_q;

  logic              sel;
  logic              accept;
  logic              sel_legal;
  logic [3:0]        sel_ctrl;
  logic [DATA_W-1:0] sel_src1, sel_src2;
  logic              owner_rsp_ready;
  logic              rsp0_active, rsp1_active;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111: is_legal = 1'b1;
      default:                                              is_legal = 1'b0;
    endcase
  endfunction

  // Pick the requester. A lone valid requester wins. On a tie, the requester
  // that did not get the last grant wins.
  always_comb begin
    sel = ~last_grant_q;
    if (req0.valid && !req1.valid) begin
      sel = 1'b0;
    end else if (req1.valid && !req0.valid) begin
      sel = 1'b1;
    end
  end

  assign accept    = (state_q == IDLE) && (req0.valid || req1.valid);
  assign sel_ctrl  = sel ? req1.ctrl : req0.ctrl;
  assign sel_src1  = sel ? req1.src1 : req0.src1;
  assign sel_src2  = sel ? req1.src2 : req0.src2;
  assign sel_legal = is_legal(sel_ctrl);
  assign owner_rsp_ready = owner_q ? req1.rsp_ready : req0.rsp_ready;

  assign req0.ready = accept && !sel;
  assign req1.ready = accept && sel;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The ALU is driven only in ISSUE. At all other times it sees a harmless
  // add of zeros, so a latched illegal code never reaches it.
  always_comb begin
    state_d    = state_q;
    alu_ctrl_o = CTRL_ADD;
    alu_src1_o = '0;
    alu_src2_o = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = sel_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        alu_ctrl_o = op_ctrl_q;
        alu_src1_o = op_src1_q;
        alu_src2_o = op_src2_q;
        state_d    = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted op on accept. The response registers are preloaded
  // with the error-path values. A legal op overwrites them from the ALU
  // during ISSUE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_ctrl_q    <= CTRL_ADD;
      op_src1_q    <= '0;
      op_src2_q    <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        owner_q      <= sel;
        last_grant_q <= sel;
        op_ctrl_q    <= sel_ctrl;
        op_src1_q    <= sel_src1;
        op_src2_q    <= sel_src2;
        result_q     <= '0;
        zero_q       <= 1'b0;
        err_q        <= ~sel_legal;
      end else if (state_q == ISSUE) begin
        result_q <= alu_result_i;
        zero_q   <= alu_zero_i;
      end
    end
  end

  // Response outputs are visible only to the owner, and only while in RESP.
  assign rsp0_active = (state_q == RESP) && !owner_q;
  assign rsp1_active = (state_q == RESP) && owner_q;

  assign req0.rsp_valid = rsp0_active;
  assign req0.result    = rsp0_active ? result_q : '0;
  assign req0.zero      = rsp0_active && zero_q;
  assign req0.err       = rsp0_active && err_q;

  assign req1.rsp_valid = rsp1_active;
  assign req1.result    = rsp1_active ? result_q : '0;
  assign req1.zero      = rsp1_active && zero_q;
  assign req1.err       = rsp1_active && err_q;

  assign busy_o = (state_q != IDLE);

endmodule
